nco_bank: RTL and testbench

- Multi-channel numerically controlled oscillator. It generalises the single fixed-divider 1 Hz generator into CH independent channels.
- Each channel has:
  - a runtime-programmable divisor, loaded glitch-free at period boundaries;
  - exact odd-divisor handling;
  - square or single-pulse output mode;
  - a per-channel enable.
- A global sync input phase-aligns all channels.
- The block sits between the 50 MHz system clock and downstream counters, display scanners and debouncers that need derived clocks or clock-enable ticks.

---
 rtl/nco_pkg.sv | 18 +
 rtl/nco_chan.sv | 129 ++++++++++++
 rtl/nco_bank.sv | 57 +++++
 tb/tb_nco_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nco_pkg
//  Description : Shared constants for the multi-channel NCO bank: output mode
//                encodings and the default reset divisor (1 Hz at 50 MHz).
//  Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

    // Output mode encodings, one bit per channel on the mode port
    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Divisor loaded into every channel at reset
    localparam int unsigned RST_DIV_DEFAULT = 32'd50_000_000;

endpackage : nco_pkg
`default_nettype wire

// File: rtl/nco_chan.sv
`default_nettype none
// ============================================================================
//  Module      : nco_chan
//  Description : One NCO channel. Period counter, active divisor, shadow
//                divisor with pending flag, registered clk_out/tick outputs.
//                The shadow is only transferred at period boundaries so the
//                output never sees a truncated or stretched period.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_chan
    import nco_pkg::*;
#(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_DIV = W'(RST_DIV_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_mode,
    input  logic         i_sync,
    input  logic         i_wr,
    input  logic [W-1:0] i_data,
    output logic         o_clk_out,
    output logic         o_tick,
    output logic         o_pending
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_div;
    logic [W-1:0] r_shadow;
    logic         r_pending;
    logic         r_en_q;
    logic         r_clk_out;
    logic         r_tick;

    logic [W-1:0] w_cnt_nx;
    logic [W-1:0] w_div_nx;
    logic [W-1:0] w_shadow_nx;
    logic [W-1:0] w_high_nx;
    logic         w_pending_nx;
    logic         w_start;
    logic         w_tick_nx;
    logic         w_clk_nx;

    // Next-state: period boundaries, shadow transfer and output decode
    always_comb begin
        w_cnt_nx     = r_cnt;
        w_div_nx     = r_div;
        w_shadow_nx  = r_shadow;
        w_pending_nx = r_pending;
        w_start      = 1'b0;

        if (!i_en) begin
            // Disabled: park the counter, let a pending divisor land at once
            w_cnt_nx = '0;
            if (r_pending) begin
                w_div_nx     = r_shadow;
                w_pending_nx = 1'b0;
            end
            if (i_wr) begin
                w_shadow_nx  = i_data;
                w_pending_nx = 1'b1;
            end
        end else if (r_div == '0) begin
            // Stopped channel: a new divisor restarts it on this very edge
            w_cnt_nx = '0;
            if (i_wr) begin
                w_div_nx     = i_data;
                w_shadow_nx  = i_data;
                w_pending_nx = 1'b0;
                w_start      = (i_data != '0);
            end else if (r_pending) begin
                w_div_nx     = r_shadow;
                w_pending_nx = 1'b0;
                w_start      = (r_shadow != '0);
            end
        end else begin
            // Running: >= compare makes any out-of-range count wrap
            w_start = !r_en_q || i_sync || (r_cnt >= r_div - W'(1));
            if (w_start) begin
                w_cnt_nx = '0;
                if (r_pending) begin
                    w_div_nx     = r_shadow;
                    w_pending_nx = 1'b0;
                end
            end else begin
                w_cnt_nx = r_cnt + W'(1);
            end
            // A write on a boundary edge is held for the following boundary
            if (i_wr) begin
                w_shadow_nx  = i_data;
                w_pending_nx = 1'b1;
            end
        end

        // ceil(D/2) high cycles; D=0 yields zero so the output stays low
        w_high_nx = w_div_nx - (w_div_nx >> 1);
        w_tick_nx = w_start && (w_div_nx != '0);
        w_clk_nx  = i_en && ((i_mode == MODE_PULSE) ? w_tick_nx
                                                    : (w_cnt_nx < w_high_nx));
    end

    // Channel state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= RST_DIV;
            r_shadow  <= RST_DIV;
            r_pending <= 1'b0;
            r_en_q    <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nx;
            r_div     <= w_div_nx;
            r_shadow  <= w_shadow_nx;
            r_pending <= w_pending_nx;
            r_en_q    <= i_en;
            r_clk_out <= w_clk_nx;
            r_tick    <= w_tick_nx;
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule : nco_chan
`default_nettype wire

// File: rtl/nco_bank.sv
`default_nettype none
// ============================================================================
//  Module      : nco_bank
//  Description : CH-channel numerically controlled oscillator. Decodes the
//                divisor write port into per-channel strobes and fans the
//                global sync out to every channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_bank
    import nco_pkg::*;
#(
    parameter int          CH      = 4,
    parameter int          W       = 32,
    parameter int unsigned RST_DIV = RST_DIV_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CH-1:0]                       en,
    input  logic [CH-1:0]                       mode,
    input  logic                                sync,
    input  logic                                div_wr,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] div_sel,
    input  logic [W-1:0]                        div_data,
    output logic [CH-1:0]                       clk_out,
    output logic [CH-1:0]                       tick,
    output logic [CH-1:0]                       pending
);

    localparam int c_SELW = (CH > 1) ? $clog2(CH) : 1;

    // Per-channel write strobes; selects >= CH match no channel
    logic [CH-1:0] w_wr;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_chan
            assign w_wr[i] = div_wr && (div_sel == c_SELW'(i));

            nco_chan #(
                .W       (W),
                .RST_DIV (W'(RST_DIV))
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .i_en      (en[i]),
                .i_mode    (mode[i]),
                .i_sync    (sync),
                .i_wr      (w_wr[i]),
                .i_data    (div_data),
                .o_clk_out (clk_out[i]),
                .o_tick    (tick[i]),
                .o_pending (pending[i])
            );
        end
    endgenerate

endmodule : nco_bank
`default_nettype wire

// File: tb/tb_nco_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nco_bank
//  Description : Self-checking bench for nco_bank. A behavioural model tracks
//                each channel's phase within its period and predicts
//                tick/clk_out/pending after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_bank;

    localparam int          CH   = 5;
    localparam int          W    = 32;
    localparam int          SELW = 3;
    localparam int unsigned RDIV = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   en;
    logic [CH-1:0]   mode;
    logic            sync;
    logic            div_wr;
    logic [SELW-1:0] div_sel;
    logic [W-1:0]    div_data;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   pending;

    nco_bank #(.CH(CH), .W(W), .RST_DIV(RDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sync     (sync),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    // Model: divisor, shadow, phase inside current period, pending, last en
    longint unsigned m_d [CH];
    longint unsigned m_sh[CH];
    longint unsigned m_ph[CH];
    bit              m_pend[CH];
    bit              m_prev[CH];
    logic [CH-1:0]   e_tick, e_clk, e_pend;

    int n_pass  = 0;
    int n_total = 0;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_d[c] = RDIV; m_sh[c] = RDIV; m_ph[c] = 0;
            m_pend[c] = 0; m_prev[c] = 0;
        end
        e_tick = '0; e_clk = '0; e_pend = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            bit w;
            bit start;
            w     = div_wr && (int'(div_sel) == c);
            start = 0;
            if (!en[c]) begin
                if (m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
                if (w) begin m_sh[c] = div_data; m_pend[c] = 1; end
                m_ph[c] = 0;
            end else if (m_d[c] == 0) begin
                if (w) begin
                    m_d[c] = div_data; m_sh[c] = div_data; m_pend[c] = 0;
                    start = (m_d[c] != 0);
                end else if (m_pend[c]) begin
                    m_d[c] = m_sh[c]; m_pend[c] = 0;
                    start = (m_d[c] != 0);
                end
                m_ph[c] = 0;
            end else begin
                // New period when freshly enabled, synced, or last cycle done
                start = !m_prev[c] || sync || (m_ph[c] + 1 >= m_d[c]);
                if (start && m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
                if (w) begin m_sh[c] = div_data; m_pend[c] = 1; end
                m_ph[c] = start ? 0 : m_ph[c] + 1;
            end
            e_tick[c] = en[c] && start && (m_d[c] != 0);
            if (!en[c])
                e_clk[c] = 0;
            else if (mode[c])
                e_clk[c] = e_tick[c];
            else
                e_clk[c] = (m_d[c] != 0) && (m_ph[c] < (m_d[c] + 1) / 2);
            e_pend[c] = m_pend[c];
            m_prev[c] = en[c];
        end
    endtask

    task automatic check(input string tag);
        n_total++;
        assert (tick === e_tick) n_pass++;
        else $error("FAIL %s tick observed=%b expected=%b", tag, tick, e_tick);
        n_total++;
        assert (clk_out === e_clk) n_pass++;
        else $error("FAIL %s clk_out observed=%b expected=%b", tag, clk_out, e_clk);
        n_total++;
        assert (pending === e_pend) n_pass++;
        else $error("FAIL %s pending observed=%b expected=%b", tag, pending, e_pend);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        check(tag);
        div_wr = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic wr(input int sel, input int unsigned data);
        div_wr = 1'b1; div_sel = SELW'(sel); div_data = data;
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    initial begin
        rst = 1'b1; en = '0; mode = '0; sync = 1'b0;
        div_wr = 1'b0; div_sel = '0; div_data = '0;
        model_reset();
        run(2, "reset");
        rst = 1'b0;
        run(2, "idle");

        // ch0: D=5 applied by sync, 3 high / 2 low
        en[0] = 1'b1; step("ch0_enable");
        wr(0, 5); step("ch0_write");
        sync = 1'b1; step("ch0_sync");
        run(16, "ch0_d5");

        // ch1: D=4, then D=1, then D=0, then restart with D=3
        en[1] = 1'b1; wr(1, 4); step("ch1_write4");
        sync = 1'b1; step("ch1_sync");
        run(10, "ch1_d4");
        wr(1, 1); step("ch1_write1");
        run(8, "ch1_d1");
        wr(1, 0); step("ch1_write0");
        run(6, "ch1_d0");
        wr(1, 3); step("ch1_restart3");
        run(8, "ch1_d3");

        // ch2: D=6 running, write 8 mid-period
        en[2] = 1'b1; wr(2, 6); step("ch2_write6");
        sync = 1'b1; step("ch2_sync");
        run(3, "ch2_d6");
        wr(2, 8); step("ch2_write8_mid");
        run(20, "ch2_d8");

        // Write coincident with boundary: old shadow applies, new one waits
        wr(2, 10); step("ch2_write10");
        for (int k = 0; k < 30 && !(m_ph[2] + 1 >= m_d[2]); k++) step("ch2_seek");
        wr(2, 3); step("ch2_coincident");
        run(18, "ch2_after");

        // D = 3,5,7,9 free-running, then a sync pulse, then async reset
        en[3] = 1'b1;
        wr(0, 3); step("set0"); wr(1, 5); step("set1");
        wr(2, 7); step("set2"); wr(3, 9); step("set3");
        run(25, "free");
        sync = 1'b1; step("bank_sync");
        run(int'($urandom_range(3, 7)), "post_sync");
        rst = 1'b1; #2; model_reset(); check("async_rst");
        step("rst_hold");
        rst = 1'b0;
        en = '1;
        run(45, "rst_div");

        // Out-of-range selects change nothing
        wr(5, 7); step("sel_oor5");
        wr(7, 2); step("sel_oor7");
        run(3, "oor_after");

        // Mode toggle on ch3
        mode[3] = 1'b1; run(22, "ch3_pulse");
        mode[3] = 1'b0; run(5, "ch3_square");

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 31) == 0) en[c]   = ~en[c];
                if ($urandom_range(0, 15) == 0) mode[c] = ~mode[c];
            end
            sync = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 5) == 0) wr(int'($urandom_range(0, 7)), $urandom_range(0, 12));
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_nco_bank
`default_nettype wire
